// File: rtl/onehot_encoder.sv
// Registered 8-to-3 one-hot encoder with legality check, even/odd counters and a latched fault state.
// Define ONEHOT_ENCODER_PRIORITY_EN to accept multi-hot words and encode their highest set bit.
module onehot_encoder (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iEN,
    input  logic       iCLR,
    input  logic [7:0] iONEHOT,
    output logic [2:0] oCODE,
    output logic       oVALID,
    output logic       oERR,
    output logic       oGREAT,
    output logic [3:0] oCNTP,
    output logic [3:0] oCNTN,
    output logic [3:0] oERRCNT,
    output logic       oFAULT
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] in_q, in_d;
    logic       v1_q, v1_d;
    logic [1:0] streak_q, streak_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       great_q, great_d;
    logic [3:0] cntp_q, cntp_d;
    logic [3:0] cntn_q, cntn_d;
    logic [3:0] errcnt_q, errcnt_d;

    logic [3:0] ones;
    logic [2:0] idx;
    logic       legal;

    // Population count and highest-set-bit index of the stage-1 word.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, in_q[i]};
            if (in_q[i]) begin
                idx = 3'(i);
            end
        end
`ifdef ONEHOT_ENCODER_PRIORITY_EN
        legal = (ones != 4'd0);
`else
        legal = (ones == 4'd1);
`endif
    end

    always_comb begin
        state_d  = state_q;
        in_d     = in_q;
        v1_d     = 1'b0;
        streak_d = streak_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        great_d  = great_q;
        cntp_d   = cntp_q;
        cntn_d   = cntn_q;
        errcnt_d = errcnt_q;

        if (iCLR) begin
            state_d  = RUN;
            in_d     = '0;
            streak_d = '0;
            code_d   = '0;
            great_d  = 1'b0;
            cntp_d   = '0;
            cntn_d   = '0;
            errcnt_d = '0;
        end else begin
            if (iEN) begin
                in_d = iONEHOT;
                v1_d = 1'b1;
            end

            if (v1_q && legal) begin
                code_d   = idx;
                great_d  = idx[2];
                streak_d = '0;
                if (state_q == RUN) begin
                    valid_d = 1'b1;
                    if (idx[0]) begin
                        cntn_d = cntn_q + 4'd1;
                    end else begin
                        cntp_d = cntp_q + 4'd1;
                    end
                end
            end else if (v1_q) begin
                err_d = 1'b1;
                if (errcnt_q != 4'hF) begin
                    errcnt_d = errcnt_q + 4'd1;
                end
                if (streak_q != 2'd3) begin
                    streak_d = streak_q + 2'd1;
                end
                // Third illegal word in a row trips the fault latch.
                if (streak_q >= 2'd2) begin
                    state_d = FAULT;
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= RUN;
            in_q     <= '0;
            v1_q     <= 1'b0;
            streak_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            great_q  <= 1'b0;
            cntp_q   <= '0;
            cntn_q   <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            in_q     <= in_d;
            v1_q     <= v1_d;
            streak_q <= streak_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            great_q  <= great_d;
            cntp_q   <= cntp_d;
            cntn_q   <= cntn_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign oCODE   = code_q;
    assign oVALID  = valid_q;
    assign oERR    = err_q;
    assign oGREAT  = great_q;
    assign oCNTP   = cntp_q;
    assign oCNTN   = cntn_q;
    assign oERRCNT = errcnt_q;
    assign oFAULT  = (state_q == FAULT);

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed plus randomized bench for onehot_encoder against a cycle-level behavioural model.
module tb_onehot_encoder;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iEN;
    logic       iCLR;
    logic [7:0] iONEHOT;
    logic [2:0] oCODE;
    logic       oVALID;
    logic       oERR;
    logic       oGREAT;
    logic [3:0] oCNTP;
    logic [3:0] oCNTN;
    logic [3:0] oERRCNT;
    logic       oFAULT;

    always #5 iCLK = ~iCLK;

    onehot_encoder dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iEN     (iEN),
        .iCLR    (iCLR),
        .iONEHOT (iONEHOT),
        .oCODE   (oCODE),
        .oVALID  (oVALID),
        .oERR    (oERR),
        .oGREAT  (oGREAT),
        .oCNTP   (oCNTP),
        .oCNTN   (oCNTN),
        .oERRCNT (oERRCNT),
        .oFAULT  (oFAULT)
    );

`ifdef ONEHOT_ENCODER_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    int total  = 0;
    int passed = 0;

    // Reference model: pending stage-1 sample plus visible output values.
    bit         p_v;
    logic [7:0] p_w;
    int m_code, m_valid, m_err, m_great, m_cntp, m_cntn, m_errcnt, m_streak;
    bit m_fault;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        p_v = 0; p_w = '0;
        m_code = 0; m_valid = 0; m_err = 0; m_great = 0;
        m_cntp = 0; m_cntn = 0; m_errcnt = 0; m_streak = 0; m_fault = 0;
    endtask

    task automatic model_process(input bit v, input logic [7:0] w);
        int n, hi;
        m_valid = 0;
        m_err   = 0;
        if (!v) return;
        n  = $countones(w);
        hi = -1;
        for (int i = 0; i < 8; i++) if (w[i]) hi = i;
        if (n == 1 || (PRIO && n > 1)) begin
            m_code   = hi;
            m_great  = (hi > 3) ? 1 : 0;
            m_streak = 0;
            if (!m_fault) begin
                m_valid = 1;
                if (hi % 2 == 0) m_cntp = (m_cntp + 1) % 16;
                else             m_cntn = (m_cntn + 1) % 16;
            end
        end else begin
            m_err    = 1;
            m_errcnt = (m_errcnt < 15) ? m_errcnt + 1 : 15;
            m_streak = m_streak + 1;
            if (m_streak >= 3) m_fault = 1;
        end
    endtask

    task automatic check_all();
        chk("code",   {5'd0, oCODE},   8'(m_code));
        chk("valid",  {7'd0, oVALID},  8'(m_valid));
        chk("err",    {7'd0, oERR},    8'(m_err));
        chk("great",  {7'd0, oGREAT},  8'(m_great));
        chk("cntp",   {4'd0, oCNTP},   8'(m_cntp));
        chk("cntn",   {4'd0, oCNTN},   8'(m_cntn));
        chk("errcnt", {4'd0, oERRCNT}, 8'(m_errcnt));
        chk("fault",  {7'd0, oFAULT},  8'(m_fault));
    endtask

    task automatic step(input bit en, input bit clr, input logic [7:0] w);
        iEN = en; iCLR = clr; iONEHOT = w;
        @(posedge iCLK);
        if (clr) begin
            model_reset();
        end else begin
            model_process(p_v, p_w);
            p_v = en;
            if (en) p_w = w;
        end
        @(negedge iCLK);
        $display("step en=%0d clr=%0d w=%02h -> code=%0d v=%0d e=%0d g=%0d p=%0d n=%0d ec=%0d f=%0d",
                 en, clr, w, oCODE, oVALID, oERR, oGREAT, oCNTP, oCNTN, oERRCNT, oFAULT);
        check_all();
    endtask

    initial begin
        logic [7:0] w;
        iRST = 1'b1; iEN = 1'b0; iCLR = 1'b0; iONEHOT = '0;
        model_reset();
        repeat (2) @(negedge iCLK);
        check_all();
        iRST = 1'b0;

        // Walking one: codes 0..7, four even and four odd.
        for (int i = 0; i < 8; i++) step(1, 0, 8'h01 << i);
        step(0, 0, 8'h00);
        chk("plan_cntp_walk", {4'd0, oCNTP}, 8'd4);
        chk("plan_cntn_walk", {4'd0, oCNTN}, 8'd4);

        // Sixteen even samples wrap oCNTP, with idle gaps.
        step(0, 1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'h04);
            if (i % 4 == 3) step(0, 0, 8'h55);
        end
        step(0, 0, 8'h00);
        chk("plan_cntp_wrap", {4'd0, oCNTP}, 8'd0);

        // Three illegal words latch FAULT; legal word then gives no pulse.
        step(0, 1, 8'h00);
        repeat (3) step(1, 0, 8'h00);
        step(1, 0, 8'h08);
        step(0, 0, 8'h00);
        chk("plan_fault", {7'd0, oFAULT}, 8'd1);
        chk("plan_code3", {5'd0, oCODE}, 8'd3);
        step(0, 1, 8'h00);

        // Legal word breaks the streak.
        foreach (w[i]) ; // no-op keeps w declared-use simple
        step(1, 0, 8'h00); step(1, 0, 8'h00); step(1, 0, 8'h10); step(1, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("plan_nofault", {7'd0, oFAULT}, 8'd0);
        chk("plan_errcnt3", {4'd0, oERRCNT}, 8'd3);

        // Multi-hot word.
        step(0, 1, 8'h00);
        step(1, 0, 8'h44);
        step(0, 0, 8'h00);

        // iCLR with iEN drops the sample.
        step(1, 0, 8'h02);
        step(1, 1, 8'h08);
        step(0, 0, 8'h00);

        // Asynchronous reset mid-stream discards the in-flight sample.
        step(1, 0, 8'h80);
        iRST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge iCLK);
        iRST = 1'b0;
        step(0, 0, 8'h00);

        // Saturation of the illegal-sample counter.
        repeat (20) step(1, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("plan_errsat", {4'd0, oERRCNT}, 8'd15);
        step(0, 1, 8'h00);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0, 3:    w = 8'h01 << $urandom_range(0, 7);
                1:       w = 8'h00;
                default: w = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, w);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/onehot_encoder.md
# onehot_encoder

Registered 8-to-3 one-hot encoder, the inverse of the team's one-hot decoder/parity-counter block. It accepts an 8-bit one-hot word, checks it for legality, and returns the 3-bit index together with a ">3" flag and running even/odd index counts. It also counts malformed words and enters a latched fault state after a burst of them. It sits on the return path wherever a decoded one-hot bus must be turned back into a binary code.

## Interface
- No parameters; all widths fixed.
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iEN  in  1  sample-enable; iONEHOT captured only when 1
- iCLR  in  1  synchronous clear/fault-exit; priority over iEN
- iONEHOT  in  8  one-hot input word
- oCODE  out  3  encoded index of last legal sample
- oVALID  out  1  one-cycle pulse: oCODE updated from a legal sample
- oERR  out  1  one-cycle pulse: illegal sample seen
- oGREAT  out  1  registered, oCODE > 3
- oCNTP  out  4  count of legal samples with even index
- oCNTN  out  4  count of legal samples with odd index
- oERRCNT  out  4  count of illegal samples, saturating
- oFAULT  out  1  1 while FSM is in FAULT

## Operation
- Stage 1: on an edge with iEN=1, sIN <= iONEHOT and sV1 <= 1. Otherwise sV1 <= 0.
- Legality of sIN:
  - Exactly one bit set: legal.
  - Zero bits set: always illegal.
  - Multiple bits set: see Configuration.
- Stage 2, on an edge with sV1=1 and a legal sIN:
  - oCODE <= index of the set bit.
  - oGREAT <= (index > 3).
  - oVALID <= 1 in RUN, 0 in FAULT.
- Stage 2, on an edge with sV1=1 and an illegal sIN:
  - oERR <= 1.
  - oCODE and oGREAT hold their values.
- Stage 2, on an edge with sV1=0: oVALID <= 0, oERR <= 0; oCODE and oGREAT hold.
- Counters update at the same edge as oVALID/oERR:
  - oCNTP +1 on a legal even index (0, 2, 4, 6), RUN only.
  - oCNTN +1 on a legal odd index, RUN only.
  - oCNTP and oCNTN are 4-bit and wrap 15 -> 0.
  - oERRCNT +1 per illegal sample in any state; saturates at 15.
- FSM, states RUN and FAULT:
  - 2-bit streak counter: +1 per illegal sample, cleared by a legal sample.
  - Cycles with sV1=0 leave the streak unchanged.
  - RUN -> FAULT on the edge that processes the 3rd consecutive illegal sample. oERR and oFAULT rise together on that edge.
  - In FAULT: oVALID is held 0, oCNTP and oCNTN are frozen. oCODE, oGREAT, oERR and oERRCNT keep updating.
  - FAULT -> RUN only via iCLR. A legal sample alone does not exit.
- iCLR=1 at an edge, from any state:
  - State goes to RUN; streak, oCNTP, oCNTN and oERRCNT go to 0.
  - sV1, oVALID and oERR go to 0; oCODE and oGREAT go to 0.
  - iEN is ignored on that edge.

## Timing
- Reset values: oCODE=0, oVALID=0, oERR=0, oGREAT=0, oCNTP=0, oCNTN=0, oERRCNT=0, oFAULT=0. Internally sIN=0, sV1=0, streak=0, state RUN.
- Latency: a word sampled at edge N appears on oCODE/oVALID/oERR after edge N+1. Throughput is one word per cycle.
- oVALID and oERR are mutually exclusive and never high two cycles for a single sample.
- Back-to-back samples with iEN held high produce back-to-back pulses.
- Reset asserted mid-stream discards the in-flight stage-1 sample; no pulse follows reset release.
- With iCLR and iEN high together, the sample is dropped and no pulse is produced.

## Configuration
- ONEHOT_ENCODER_PRIORITY_EN defined:
  - Multi-hot sIN is legal and encodes the highest set bit. Example: 8'b0100_0100 -> 6.
  - oERR is not raised for it and the streak clears.
- ONEHOT_ENCODER_PRIORITY_EN undefined:
  - Multi-hot sIN is illegal: oERR pulses, oERRCNT and streak increment, oCODE holds.

## Test plan
- Reset, then iEN=1 with iONEHOT=01, 02, 04 … 80 on consecutive cycles -> oCODE=0..7 one cycle late, oVALID high 8 cycles, oGREAT=1 for codes 4-7, final oCNTP=4, oCNTN=4.
- 16 consecutive legal even samples (iONEHOT=04) -> oCNTP wraps to 0, oCNTN stays 0; iEN=0 gaps produce no pulses.
- iONEHOT=00, 00, 00 -> three oERR pulses, oFAULT=1 on the 3rd, oERRCNT=3. Then 08 -> oVALID=0, oCODE=3, counters frozen. Then iCLR -> all counts 0, oFAULT=0.
- iONEHOT=00, 00, 10, 00 -> no FAULT, since the legal sample clears the streak; oERRCNT=3.
- iONEHOT=8'h44 -> oERR=1 without the macro; oCODE=6 and oVALID=1 with ONEHOT_ENCODER_PRIORITY_EN.
- iRST asserted the cycle after sampling 80 -> no oVALID pulse, all outputs 0; 20 illegal samples -> oERRCNT saturates at 15.
